// File: rtl/ms_ctrl_pkg.sv
// Shared types and constants for the millisecond counter controller.
package ms_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int         BCD_W    = 4;
  localparam int         N_DIGITS = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the millisecond count; carry is combinational so a
// single increment ripples through every digit within the same cycle.
module bcd_digit
  import ms_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= carry ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/ms_counter_ctrl.sv
// Run/stop/clear controller: input synchronizers, run FSM, 1 ms prescaler
// and a saturating 4-digit BCD millisecond count with overflow flag.
module ms_counter_ctrl
  import ms_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int PRE_W    = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clr,
  output logic [BCD_W*N_DIGITS-1:0] ms_bcd,
  output logic                      ms_tick,
  output logic                      running,
  output logic                      ovf
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [2:0]          sync_p0, sync_p1, sync_p2;  // {clr, stop, start}
  logic [2:0]          ev;
  logic                clr_ev, stop_ev, start_ev;
  state_t              state, state_nxt;
  logic [PRE_W-1:0]    pre, pre_nxt;
  logic                tick_inc, ovf_set, sat;
  logic [N_DIGITS-1:0] inc_d, carry_d;
  logic                carry_unused;

  // Stage p0/p1 synchronize, p2 delays for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= {clr, stop, start};
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign ev       = sync_p1 & ~sync_p2;
  assign clr_ev   = ev[2];
  assign stop_ev  = ev[1] & ~ev[2];
  assign start_ev = ev[0] & ~ev[1] & ~ev[2];

  assign sat = (ms_bcd == {N_DIGITS{BCD_MAX}});

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    tick_inc  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        pre_nxt = '0;
        if (start_ev) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_ev) begin
          state_nxt = ST_HOLD;
        end else if (pre == PRE_LAST) begin
          pre_nxt = '0;
          if (sat) begin
            ovf_set   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            tick_inc = 1'b1;
          end
        end else begin
          pre_nxt = pre + 1'b1;
        end
      end
      ST_HOLD: begin
        if (start_ev && !ovf) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr_ev) begin
      state_nxt = ST_IDLE;
      pre_nxt   = '0;
      tick_inc  = 1'b0;
      ovf_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pre     <= '0;
      ms_tick <= 1'b0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre     <= pre_nxt;
      ms_tick <= tick_inc;
      running <= (state_nxt == ST_RUN);
      ovf     <= clr_ev ? 1'b0 : (ovf | ovf_set);
    end
  end

  // Units digit takes the tick; each higher digit takes the carry below it
  assign inc_d        = {carry_d[N_DIGITS-2:0], tick_inc};
  assign carry_unused = carry_d[N_DIGITS-1];

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_ev),
      .inc   (inc_d[i]),
      .q     (ms_bcd[i*BCD_W +: BCD_W]),
      .carry (carry_d[i])
    );
  end

endmodule

// File: tb/tb_ms_counter_ctrl.sv
// Bench for ms_counter_ctrl: directed stimulus with a tick scoreboard,
// plus a fast-prescaler instance to reach the 9999 saturation point.
module tb_ms_counter_ctrl;

  typedef struct {
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in1, in2;  // {clr, stop, start}
  logic [15:0] bcd1, bcd2;
  logic        tick1, tick2, run1, run2, ovf1, ovf2;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q1[$];
  exp_t        q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ms_counter_ctrl #(.TICK_DIV(10), .PRE_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (in1[0]),
    .stop    (in1[1]),
    .clr     (in1[2]),
    .ms_bcd  (bcd1),
    .ms_tick (tick1),
    .running (run1),
    .ovf     (ovf1)
  );

  ms_counter_ctrl #(.TICK_DIV(2), .PRE_W(1)) dut_fast (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (in2[0]),
    .stop    (in2[1]),
    .clr     (in2[2]),
    .ms_bcd  (bcd2),
    .ms_tick (tick2),
    .running (run2),
    .ovf     (ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; the inputs are high across exactly one rising edge
  task automatic pulse(input int which, input logic [2:0] m);
    if (which == 1) in1 = m; else in2 = m;
    @(negedge clk);
    if (which == 1) in1 = 3'b000; else in2 = 3'b000;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic push(input int which, input int n, input int c);
    exp_t e;
    e.bcd = to_bcd(n);
    e.cyc = c;
    if (which == 1) q1.push_back(e); else q2.push_back(e);
  endtask

  // Scoreboard monitor: every tick must match the next expected count and cycle
  always @(negedge clk) begin
    if (tick1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick1_unexpected: got tick with count %0h at cycle %0d, expected none", bcd1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("tick1_count", 32'(bcd1), 32'(e.bcd));
        check("tick1_cycle", cyc, e.cyc);
      end
    end
    if (tick2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick2_unexpected: got tick with count %0h at cycle %0d, expected none", bcd2, cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("tick2_count", 32'(bcd2), 32'(e.bcd));
        check("tick2_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t, c;
    rst_n = 1'b0;
    in1   = 3'b000;
    in2   = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd1), 32'h0);
    check("rst_run", 32'(run1), 32'h0);
    check("rst_tick", 32'(tick1), 32'h0);
    check("rst_ovf", 32'(ovf1), 32'h0);
    check("rst_fast_bcd", 32'(bcd2), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start and count, then asynchronous reset mid-run at 0042
    t = cyc;
    pulse(1, 3'b001);
    for (int k = 1; k <= 42; k++) push(1, k, t + 3 + 10 * k);
    wait_cyc(t + 2);   check("run_before_e3", 32'(run1), 32'h0);
    wait_cyc(t + 3);   check("run_at_e3", 32'(run1), 32'h1);
    wait_cyc(t + 253); check("count_0025", 32'(bcd1), 32'h0025);
    wait_cyc(t + 425); check("count_0042", 32'(bcd1), 32'h0042);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_bcd", 32'(bcd1), 32'h0);
    check("midrun_rst_run", 32'(run1), 32'h0);
    check("midrun_rst_tick", 32'(tick1), 32'h0);
    check("midrun_rst_ovf", 32'(ovf1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    wait_cyc(t + 30);
    check("idle_bcd", 32'(bcd1), 32'h0);
    check("idle_run", 32'(run1), 32'h0);

    // Pause at 0007 with prescaler 4, resume after 100 cycles
    t = cyc;
    pulse(1, 3'b001);
    for (int k = 1; k <= 7; k++) push(1, k, t + 3 + 10 * k);
    wait_cyc(t + 75);  pulse(1, 3'b010);
    wait_cyc(t + 77);  check("run_before_stop", 32'(run1), 32'h1);
    wait_cyc(t + 78);  check("run_after_stop", 32'(run1), 32'h0);
    wait_cyc(t + 178);
    check("hold_count", 32'(bcd1), 32'h0007);
    check("hold_run", 32'(run1), 32'h0);
    c = cyc;
    pulse(1, 3'b001);
    push(1, 8, c + 9);
    push(1, 9, c + 19);
    wait_cyc(c + 3);   check("resume_run", 32'(run1), 32'h1);
    wait_cyc(c + 20);  pulse(1, 3'b100);
    wait_cyc(c + 23);
    check("clr_after_resume_bcd", 32'(bcd1), 32'h0);
    check("clr_after_resume_run", 32'(run1), 32'h0);

    // Priority: all three together in RUN at 0123
    t = cyc;
    pulse(1, 3'b001);
    for (int k = 1; k <= 123; k++) push(1, k, t + 3 + 10 * k);
    wait_cyc(t + 1235); check("count_0123", 32'(bcd1), 32'h0123);
    pulse(1, 3'b111);
    wait_cyc(t + 1237); check("prio_run_before", 32'(run1), 32'h1);
    wait_cyc(t + 1238);
    check("prio_bcd", 32'(bcd1), 32'h0);
    check("prio_run", 32'(run1), 32'h0);
    check("prio_ovf", 32'(ovf1), 32'h0);

    // STOP with START in HOLD stays in HOLD; a later START resumes
    c = cyc;
    pulse(1, 3'b001);
    push(1, 1, c + 13);
    push(1, 2, c + 23);
    wait_cyc(c + 25);  pulse(1, 3'b010);
    wait_cyc(c + 40);  pulse(1, 3'b011);
    wait_cyc(c + 45);
    check("hold_prio_run", 32'(run1), 32'h0);
    check("hold_prio_bcd", 32'(bcd1), 32'h0002);
    wait_cyc(c + 50);  pulse(1, 3'b001);
    push(1, 3, c + 59);
    wait_cyc(c + 53);  check("hold_resume_run", 32'(run1), 32'h1);
    wait_cyc(c + 60);  check("hold_resume_bcd", 32'(bcd1), 32'h0003);
    wait_cyc(c + 62);  pulse(1, 3'b100);
    wait_cyc(c + 65);  check("hold_clr_bcd", 32'(bcd1), 32'h0);

    // START held high 500 cycles, then STOP pulse, then 1-cycle CLR glitch
    c = cyc;
    in1 = 3'b001;
    for (int k = 1; k <= 50; k++) push(1, k, c + 3 + 10 * k);
    wait_cyc(c + 500); in1 = 3'b000;
    wait_cyc(c + 502); pulse(1, 3'b010);
    wait_cyc(c + 506);
    check("held_start_run", 32'(run1), 32'h0);
    check("held_start_bcd", 32'(bcd1), 32'h0050);
    wait_cyc(c + 540);
    check("held_start_still", 32'(bcd1), 32'h0050);
    c = cyc;
    pulse(1, 3'b100);
    wait_cyc(c + 2);   check("glitch_before", 32'(bcd1), 32'h0050);
    wait_cyc(c + 3);   check("glitch_clr", 32'(bcd1), 32'h0);

    // Carry chain and saturation on the fast instance
    c = cyc;
    pulse(2, 3'b001);
    for (int k = 1; k <= 9999; k++) push(2, k, c + 3 + 2 * k);
    wait_cyc(c + 2001);  check("carry_0999", 32'(bcd2), 32'h0999);
    wait_cyc(c + 2003);  check("carry_1000", 32'(bcd2), 32'h1000);
    wait_cyc(c + 19999); check("count_9998", 32'(bcd2), 32'h9998);
    wait_cyc(c + 20002);
    check("sat_pre_ovf", 32'(ovf2), 32'h0);
    check("sat_pre_run", 32'(run2), 32'h1);
    check("sat_pre_bcd", 32'(bcd2), 32'h9999);
    wait_cyc(c + 20003);
    check("sat_ovf", 32'(ovf2), 32'h1);
    check("sat_run", 32'(run2), 32'h0);
    check("sat_tick", 32'(tick2), 32'h0);
    check("sat_bcd", 32'(bcd2), 32'h9999);
    wait_cyc(c + 20010); pulse(2, 3'b001);
    wait_cyc(c + 20015); check("sat_start_ignored", 32'(run2), 32'h0);
    wait_cyc(c + 20025);
    check("sat_hold_bcd", 32'(bcd2), 32'h9999);
    check("sat_hold_ovf", 32'(ovf2), 32'h1);
    pulse(2, 3'b100);
    wait_cyc(c + 20028);
    check("sat_clr_bcd", 32'(bcd2), 32'h0);
    check("sat_clr_ovf", 32'(ovf2), 32'h0);
    check("sat_clr_run", 32'(run2), 32'h0);

    repeat (20) @(negedge clk);
    check("ticks_missing_main", q1.size(), 0);
    check("ticks_missing_fast", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_counter_ctrl.md
# ms_counter_ctrl

Run/stop/clear controller for the millisecond counter datapath. Synchronizes the START, STOP and CLR operator inputs and runs a three-state FSM. Divides CLK into a 1 ms enable tick and sequences a 4-digit BCD millisecond count (0000–9999) with saturation and overflow flagging. Sits between the button inputs and the display/JK counter chain; all counting is gated by this block.

## Interface
- TICK_DIV, 100000, CLK cycles per 1 ms tick (100 MHz CLK); benches use 10; legal range ≥ 2
- PRE_W, 17, prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV
- CLK  in  1  system clock, rising-edge active
- RST  in  1  reset, asynchronous, active-low; clears all state while low
- START  in  1  async level input; rising edge starts or resumes counting
- STOP  in  1  async level input; rising edge pauses counting
- CLR  in  1  async level input; rising edge clears count and returns to IDLE
- MS_BCD  out  16  count, 4 BCD digits; [15:12] thousands … [3:0] units
- MS_TICK  out  1  one-cycle pulse on each count increment
- RUNNING  out  1  high in RUN
- OVF  out  1  sticky; set when count saturates at 9999

## Operation
- Reset (RST low): state=IDLE, MS_BCD=0000, prescaler=0, MS_TICK=0, RUNNING=0, OVF=0, synchronizer flops=0. Takes effect immediately, including mid-count.
- Each input passes through a 2-flop synchronizer, then a third flop. Event = sync2 & ~sync3, so one rising edge gives one event.
- Event priority in the same cycle: CLR > STOP > START. Lower-priority events in that cycle are discarded.
- FSM states:
  - IDLE: count=0000, prescaler=0. START → RUN. STOP ignored. CLR → IDLE.
  - RUN: prescaler increments each cycle. At TICK_DIV-1 the prescaler wraps to 0, the count increments and MS_TICK pulses. STOP → HOLD. CLR → IDLE. START ignored.
  - HOLD: count and prescaler frozen. START → RUN, resuming from the frozen prescaler value. CLR → IDLE.
- Saturation: an increment from 9999 does not happen. The count stays at 9999, OVF sets, MS_TICK is not pulsed and the state goes to HOLD. START in HOLD while OVF=1 is ignored. Only CLR or reset clears OVF.
- BCD arithmetic: a units digit at 9 with increment goes to 0 and carries. The carry ripples combinationally through all 4 digits within the same cycle. Digits never hold values above 9.
- CLR in any state: count=0000, prescaler=0, OVF=0, state=IDLE, all on the same edge.

## Timing
- Input-to-action latency: if an input is high at CLK edge e1, the event is seen after e2 and the state/outputs change at e3.
- RUNNING is registered and follows the state directly. It rises at the e3 of START and falls at the e3 of STOP.
- First increment occurs TICK_DIV cycles after entering RUN from IDLE. After a resume it occurs TICK_DIV − (frozen prescaler) cycles after entering RUN.
- MS_TICK is high for exactly the one cycle following the incrementing edge. MS_BCD updates on the same edge.
- STOP event on the same edge as a prescaler wrap: the increment is suppressed and the prescaler freezes at TICK_DIV-1. On resume, the increment occurs on the first RUN cycle.
- Inputs held high produce no further events. Pulses shorter than one CLK period may be missed; this is permitted.

## Structure
- Package ms_ctrl_pkg holds:
  - state enum ST_IDLE / ST_RUN / ST_HOLD (2 bits)
  - BCD_W=4, N_DIGITS=4, BCD_MAX=4'd9
- Sub-module bcd_digit:
  - ports: CLK, RST, clr, inc, q[3:0], carry
  - carry = inc & (q==9)
  - instantiated 4×, with the inc inputs chained through the carries
  - top-level saturation check (all digits 9) blocks inc to the units digit
- Top holds the synchronizers, edge detect, FSM, prescaler and OVF flop.

## Test plan
All with TICK_DIV=10.
- Reset: RST low mid-RUN at count 0042 → outputs 0000/0/0/0 immediately. After release, 30 idle cycles → no change.
- Start/count: START pulse, then 10·25 cycles → MS_BCD=0025, 25 MS_TICK pulses each 10 cycles apart, RUNNING=1 starting 3 edges after START.
- Pause/resume: STOP at count 0007 with prescaler 4; wait 100 cycles → count=0007 held. START → next increment 6 cycles after RUNNING rises.
- Carry chain: run to 0999 → next tick gives 1000. Run to 9998 → 9999, then next wrap point → OVF=1, RUNNING=0, no MS_TICK. START → ignored.
- Priority: START, STOP and CLR rising together in RUN at 0123 → 0000, IDLE, OVF=0. STOP and START together in HOLD → stays HOLD.
- Edge detect: START held high 500 cycles, then STOP pulsed → exactly one start event and one stop event. A 1-cycle CLR glitch aligned to the sampling edge → clear occurs.
